// File: rtl/button_falling_edge_toggle.sv
// Toggles a registered LED once per falling edge of an active-low, asynchronous
// push button: synchronizer, optional debounce, edge detect, toggle register.
module button_falling_edge_toggle #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic led
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   deb_level;
    logic                   prev_q;
    logic                   press;

    // Stages reset to 1 so a released button never looks like a press after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic          level_q;

            // A new level is accepted only after it has differed for DEBOUNCE_CYCLES edges.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                end else if (sync != level_q) begin
                    if (cnt_q == LAST) begin
                        level_q <= sync;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign deb_level = level_q;
        end else begin : g_no_debounce
            assign deb_level = sync;
        end
    endgenerate

    assign press = prev_q & ~deb_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
            led    <= 1'b0;
        end else begin
            prev_q <= deb_level;
            if (press) begin
                led <= ~led;
            end
        end
    end

endmodule

// File: tb/tb_button_falling_edge_toggle.sv
// Directed bench: a table of per-edge vectors for the undebounced instance,
// plus hand-written debounce sequences on a second instance with DEBOUNCE_CYCLES=4.
module tb_button_falling_edge_toggle;

    logic clock;
    logic reset;
    logic b0;
    logic b4;
    logic led0;
    logic led4;

    int total;
    int bad;

    typedef struct {
        logic rst;
        logic btn;
        logic exp_led;
    } vec_t;

    vec_t vecs[$];

    button_falling_edge_toggle #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .button_n(b0), .led(led0)
    );

    button_falling_edge_toggle #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset), .button_n(b4), .led(led4)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic void add(input logic r, input logic b, input logic e);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp_led = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: led=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive before edge, check just after it.
    task automatic step4(input logic btn, input logic exp, input string name);
        @(negedge clock);
        b4 = btn;
        @(posedge clock);
        #1;
        check(name, led4, exp);
    endtask

    initial begin
        logic m;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        b0    = 1'b1;
        b4    = 1'b1;

        // Reset for 3 edges, then 10 idle edges.
        for (int i = 0; i < 3; i++) add(1, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0);
        // Press held 5 edges: led rises at the third edge (E2).
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 1); add(0, 0, 1); add(0, 0, 1);
        // Reset while led=1 and button low: cleared on first reset edge.
        for (int i = 0; i < 3; i++) add(1, 0, 0);
        // Release reset with button still low: one press, led=1 at third edge.
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 1); add(0, 0, 1); add(0, 0, 1);
        // Release never toggles.
        for (int i = 0; i < 4; i++) add(0, 1, 1);
        add(1, 1, 0); add(1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0);
        // 15 toggles every 5 cycles starting from 1: 8 presses, ends 0.
        m = 1'b0;
        for (int seg = 0; seg < 16; seg++) begin
            for (int j = 0; j < 5; j++) begin
                if ((seg % 2 == 1) && j == 2) m = ~m;
                add(0, (seg % 2 == 0) ? 1'b1 : 1'b0, m);
            end
        end
        for (int i = 0; i < 3; i++) add(0, 1, 0);
        // Reset on the edge where press=1: reset wins, no toggle afterward.
        add(0, 0, 0); add(0, 0, 0); add(1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst;
            b0    = vecs[i].btn;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), led0, vecs[i].exp_led);
        end

        // Debounced instance: still 0 after the shared reset sequence.
        check("deb_idle", led4, 1'b0);
        // 2-cycle glitch ignored.
        step4(0, 0, "glitch2_a"); step4(0, 0, "glitch2_b");
        for (int i = 0; i < 8; i++) step4(1, 0, "glitch2_after");
        // 3-cycle glitch (one short of DEBOUNCE_CYCLES) ignored.
        for (int i = 0; i < 3; i++) step4(0, 0, "glitch3");
        for (int i = 0; i < 8; i++) step4(1, 0, "glitch3_after");
        // 10-cycle pulse: toggles at edge E6 (SYNC_STAGES+4 after E0).
        for (int i = 0; i < 10; i++) step4(0, (i >= 6) ? 1'b1 : 1'b0, $sformatf("pulse10_e%0d", i));
        for (int i = 0; i < 12; i++) step4(1, 1, "pulse10_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
